// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types and constants for the Life sequencer
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GEN_W = 8;

    function automatic int cells(input int x, input int y);
        return x * y;
    endfunction

endpackage

// File: rtl/life_seq_if.sv
// rtl/life_seq_if.sv - key inputs and datapath control outputs of the Life sequencer
interface life_seq_if
    import life_pkg::*;
#(
    parameter int CW = 6
);

    logic             key_run;
    logic             key_step;
    logic [CW-1:0]    cnt;
    logic             nxt_bit;
    logic             busy;
    logic             running;
    logic             edit_en;
    logic             gen_done;
    logic [GEN_W-1:0] gen_count;

    modport master (
        input  key_run, key_step,
        output cnt, nxt_bit, busy, running, edit_en, gen_done, gen_count
    );

    modport slave (
        output key_run, key_step,
        input  cnt, nxt_bit, busy, running, edit_en, gen_done, gen_count
    );

endinterface

// File: rtl/life_gen_timer.sv
// rtl/life_gen_timer.sv - generation-rate prescaler with registered wrap pulse
module life_gen_timer #(
    parameter int GEN_DIV = 16,
    parameter int LOG2DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam logic [LOG2DIV-1:0] LAST = LOG2DIV'(GEN_DIV - 1);

    logic [LOG2DIV-1:0] count;

    // The counter holds during the wrap cycle, so a full GEN_DIV idle cycles
    // precede every start in addition to the start cycle itself.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= enable && !wrap && (count == LAST);
            if (enable && !wrap) begin
                count <= (count == LAST) ? '0 : count + LOG2DIV'(1);
            end
        end
    end

endmodule

// File: rtl/life_seq.sv
// rtl/life_seq.sv - run/step/rate sequencer driving the Life cell datapath
module life_seq
    import life_pkg::*;
#(
    parameter int X       = 8,
    parameter int Y       = 8,
    parameter int LOG2X   = 3,
    parameter int LOG2Y   = 3,
    parameter int GEN_DIV = 16,
    parameter int LOG2DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    life_seq_if.master bus
);

    localparam int            CW        = LOG2X + LOG2Y;
    localparam int            CELLS     = cells(X, Y);
    localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt_d;
    logic             nxt_d;
    logic             done_d;
    logic [GEN_W-1:0] gen_count_d;
    logic             wrap;
    logic             start;
    logic             last_cell;

    life_gen_timer #(
        .GEN_DIV (GEN_DIV),
        .LOG2DIV (LOG2DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (state == IDLE && bus.running),
        .clear  (bus.key_run),
        .wrap   (wrap)
    );

    // Explicit compare so non-power-of-two boards wrap correctly.
    assign last_cell = (bus.cnt == LAST_CELL);
    assign start     = (state == IDLE) &&
                       (wrap || (bus.key_step && !bus.running && !bus.key_run));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.cnt       <= '0;
            bus.nxt_bit   <= 1'b0;
            bus.gen_done  <= 1'b0;
            bus.gen_count <= '0;
            bus.running   <= 1'b0;
        end else begin
            state         <= state_d;
            bus.cnt       <= cnt_d;
            bus.nxt_bit   <= nxt_d;
            bus.gen_done  <= done_d;
            bus.gen_count <= gen_count_d;
            if (bus.key_run) begin
                bus.running <= !bus.running;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_cell) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; gen_count steps on entry to DONE
    // so it is already updated while gen_done is high.
    always_comb begin
        cnt_d       = '0;
        nxt_d       = 1'b0;
        done_d      = 1'b0;
        gen_count_d = bus.gen_count;
        case (state)
            IDLE: nxt_d = start;
            CALC: begin
                if (last_cell) begin
                    done_d      = 1'b1;
                    gen_count_d = bus.gen_count + GEN_W'(1);
                end else begin
                    cnt_d = bus.cnt + CW'(1);
                    nxt_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.edit_en = (state == IDLE) && !bus.running;

endmodule

// File: tb/tb_life_seq.sv
// tb/tb_life_seq.sv - directed self-checking bench for life_seq
module tb_life_seq;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    life_seq_if #(.CW(6)) bus ();

    life_seq #(
        .X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .GEN_DIV(16), .LOG2DIV(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int gexp;
        int strobes;
        int idle_strobes;

        reset        = 1'b1;
        bus.key_run  = 1'b0;
        bus.key_step = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_cnt",       bus.cnt,       0);
        check("rst_nxt_bit",   bus.nxt_bit,   0);
        check("rst_busy",      bus.busy,      0);
        check("rst_running",   bus.running,   0);
        check("rst_gen_done",  bus.gen_done,  0);
        check("rst_gen_count", bus.gen_count, 0);
        check("rst_edit_en",   bus.edit_en,   1);
        idle_strobes = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.nxt_bit) idle_strobes++;
        end
        check("idle_no_strobe", idle_strobes, 0);

        // single step while paused
        bus.key_step = 1'b1;
        tick();
        bus.key_step = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check("step_nxt_bit",  bus.nxt_bit,  1);
            check("step_cnt",      bus.cnt,      i);
            check("step_busy",     bus.busy,     1);
            check("step_edit_en",  bus.edit_en,  0);
            check("step_gen_done", bus.gen_done, 0);
            tick();
        end
        check("step_done",       bus.gen_done,  1);
        check("step_gen_count",  bus.gen_count, 1);
        check("step_done_busy",  bus.busy,      1);
        check("step_done_nxt",   bus.nxt_bit,   0);
        check("step_done_edit",  bus.edit_en,   0);
        tick();
        check("step_after_busy", bus.busy,      0);
        check("step_after_edit", bus.edit_en,   1);
        check("step_after_done", bus.gen_done,  0);

        // free run, stray steps, then pause mid-generation at k=450
        bus.key_run = 1'b1;
        tick();
        bus.key_run = 1'b0;
        gexp    = 1;
        strobes = 0;
        for (int k = 1; k <= 520; k++) begin
            int s;
            int ph;
            bit act, e_nxt, e_done, e_busy, e_run, e_edit;
            int e_cnt;
            s      = k - 17;
            ph     = (s >= 0) ? (s % 82) : -1;
            act    = (s >= 0) && (ph <= 65) && ((k - ph) <= 450);
            e_nxt  = act && (ph >= 1) && (ph <= 64);
            e_cnt  = e_nxt ? ph - 1 : 0;
            e_done = act && (ph == 65);
            e_busy = act && (ph >= 1);
            e_run  = (k <= 450);
            e_edit = !e_busy && !e_run;
            check("run_nxt_bit",  bus.nxt_bit,  e_nxt);
            check("run_cnt",      bus.cnt,      e_cnt);
            check("run_gen_done", bus.gen_done, e_done);
            check("run_busy",     bus.busy,     e_busy);
            check("run_running",  bus.running,  e_run);
            check("run_edit_en",  bus.edit_en,  e_edit);
            if (bus.nxt_bit) strobes++;
            if (e_done) begin
                gexp = (gexp + 1) % 256;
                check("run_gen_count", bus.gen_count, gexp);
                check("run_strobes",   strobes,       64);
                strobes = 0;
            end
            bus.key_step = (ph == 31) || (ph == 70 && k < 450);
            bus.key_run  = (k == 450);
            tick();
        end
        bus.key_step = 1'b0;
        bus.key_run  = 1'b0;
        check("run_final_count", bus.gen_count, 7);

        // simultaneous run and step while idle and paused
        bus.key_run  = 1'b1;
        bus.key_step = 1'b1;
        tick();
        bus.key_run  = 1'b0;
        bus.key_step = 1'b0;
        check("both_running", bus.running, 1);
        for (int j = 1; j <= 17; j++) begin
            check("both_busy", bus.busy,    0);
            check("both_nxt",  bus.nxt_bit, 0);
            tick();
        end
        check("both_first_nxt", bus.nxt_bit, 1);
        check("both_first_cnt", bus.cnt,     0);
        repeat (40) tick();
        check("pre_reset_cnt", bus.cnt, 40);

        // reset mid-generation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cnt",       bus.cnt,       0);
        check("mid_rst_nxt",       bus.nxt_bit,   0);
        check("mid_rst_done",      bus.gen_done,  0);
        check("mid_rst_gen_count", bus.gen_count, 0);
        check("mid_rst_running",   bus.running,   0);
        check("mid_rst_busy",      bus.busy,      0);
        tick();
        check("mid_rst_edit_en",   bus.edit_en,   1);
        for (int i = 0; i < 70; i++) begin
            check("post_rst_done", bus.gen_done, 0);
            check("post_rst_nxt",  bus.nxt_bit,  0);
            tick();
        end

        // 256 single steps wrap the generation counter
        for (int i = 0; i < 256; i++) begin
            bus.key_step = 1'b1;
            tick();
            bus.key_step = 1'b0;
            repeat (65) tick();
            if (i == 0)   check("wrap_first", bus.gen_count, 1);
            if (i == 254) check("wrap_255",   bus.gen_count, 255);
        end
        check("wrap_zero", bus.gen_count, 0);
        check("wrap_idle", bus.busy,      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/life_seq.md
Name: life_seq

Overview:
- Sequencer for the Life cell datapath (cell shift pipe, neighbour/sum logic, cursor editor).
- Decides when a new generation is computed, using run/pause mode, a single-step key and a generation-rate prescaler.
- During a generation it drives the cell index `cnt` and the per-cell shift strobe `nxt_bit`.
- Between generations it holds the datapath still and enables cursor edits.

Parameters:
- X, 8, board width in cells
- Y, 8, board height in cells
- LOG2X, 3, bits for an X coordinate
- LOG2Y, 3, bits for a Y coordinate
- GEN_DIV, 16, clock cycles between generation starts in run mode; minimum 2
- LOG2DIV, 4, prescaler counter width; must satisfy 2**LOG2DIV >= GEN_DIV

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_run  in  1  one-cycle pulse (debounced upstream); toggles run/pause
- key_step  in  1  one-cycle pulse; computes one generation while paused
- cnt  out  LOG2X+LOG2Y  index of the cell being computed; row-major, 0 = LSB cell
- nxt_bit  out  1  shift strobe to the cell pipe; one pulse per cell
- busy  out  1  high while a generation is in progress
- running  out  1  1 = run mode, 0 = paused
- edit_en  out  1  high when cursor flips are permitted
- gen_done  out  1  one-cycle pulse when a generation completes
- gen_count  out  8  generation counter; wraps 255 -> 0

Behaviour:
- Reset (synchronous, high, wins over everything, including mid-generation):
  - state = IDLE; cnt = 0; nxt_bit = 0; busy = 0; running = 0; gen_done = 0; gen_count = 0; prescaler = 0.
  - Consequence: edit_en = 1 one cycle after reset deasserts.
- Constant: CELLS = X*Y.
- All outputs are registered except busy and edit_en, which are decoded from the registered state.
- busy = (state != IDLE).
- edit_en = (state == IDLE) && !running.
- key_run:
  - Any cycle, any state: running toggles on the next edge.
  - The generation in progress always completes.
  - The prescaler clears to 0 on every toggle.
- Prescaler:
  - Counts only when state == IDLE and running == 1.
  - At GEN_DIV-1 it wraps to 0 and raises an internal start.
- Start sources:
  - Prescaler wrap in run mode.
  - key_step when state == IDLE and running == 0 and key_run == 0.
  - key_step in any other situation is dropped, not queued.
  - If key_run and key_step arrive in the same cycle, the toggle is taken and the step is ignored.
- FSM states are IDLE, CALC and DONE.
  - IDLE -> CALC on start. The first nxt_bit is high in the cycle after the start cycle, with cnt = 0.
  - CALC: nxt_bit = 1 every cycle and cnt increments each cycle, 0 .. CELLS-1, exactly CELLS strobes. The cycle with cnt = CELLS-1 is the last CALC cycle. Next state is DONE, with cnt = 0 and nxt_bit = 0.
  - DONE (one cycle): gen_done = 1; gen_count increments modulo 256; next state is IDLE.
  - IDLE: nxt_bit = 0 and cnt is held at 0.
- Latency:
  - start -> first strobe: 1 cycle.
  - start -> gen_done: CELLS+1 cycles.
  - Minimum period between run-mode generations: CELLS + 2 + GEN_DIV cycles.
- Width rules:
  - cnt is exactly LOG2X+LOG2Y bits.
  - For power-of-two boards, the wrap at CELLS-1 equals natural overflow. For other boards an explicit compare is required.
- Pause during CALC: the generation finishes and gen_done fires. The FSM then stays in IDLE, and edit_en rises in the same cycle that state returns to IDLE.

Decomposition:
- Shared package life_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the CELLS localparam function of X, Y;
  - the gen_count width constant (8).
- One sub-module: life_gen_timer.
  - Contains the GEN_DIV prescaler, with inputs enable and clear and output wrap pulse.
- FSM, cnt and gen_count stay in life_seq.

Test Plan (X=Y=8, GEN_DIV=16):
- Reset held 3 cycles then released -> all outputs 0 except edit_en = 1; 20 idle cycles produce no nxt_bit.
- key_step pulse at cycle t while paused:
  - nxt_bit high on t+1..t+64, with cnt 0..63 in order;
  - gen_done at t+65, gen_count = 1;
  - busy high t+1..t+65;
  - edit_en low t+1..t+65.
- key_run pulse, then free run for 300 cycles:
  - generations start every 82 cycles;
  - exactly 64 strobes each;
  - gen_count increments by 1 per gen_done;
  - edit_en = 0 throughout.
- key_step at cnt = 30 mid-CALC, and key_step while running -> no extra generation; strobe count per generation stays 64.
- key_run and key_step in the same idle-paused cycle -> running = 1, no immediate generation; first start 16 cycles later.
- Reset asserted at cnt = 40 -> next cycle cnt = 0, nxt_bit = 0, no gen_done, gen_count = 0.
- Separately, 256 single-steps -> gen_count wraps to 0.
